// File: rtl/local_ram_pkg.sv
// Shared types and helpers for the local RAM scratchpad and its response path.
package local_ram_pkg;

    localparam int unsigned DEF_LANES  = 4;
    localparam int unsigned DATA_WIDTH = 8 * DEF_LANES;
    localparam int unsigned LANE_BITS  = $clog2(DEF_LANES);
    localparam int unsigned WORD_BITS  = 32 - LANE_BITS;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } rd_rsp_t;

    // Byte address -> word index; the caller compares the full result against
    // DEPTH so that aliasing high addresses are flagged instead of wrapping.
    function automatic logic [63:0] word_index(input logic [63:0] addr,
                                               input int unsigned lane_bits);
        return addr >> lane_bits;
    endfunction

endpackage

// File: rtl/local_ram_rsp_fifo.sv
// First-word-fall-through response FIFO; storage is reset so the head reads 0
// after reset, and nothing moves while i_clk_en is low.
module local_ram_rsp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clk_en,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign do_push = i_clk_en & i_push & (count_q != CNT_W'(DEPTH));
    assign do_pop  = i_clk_en & i_pop & (count_q != '0);
    assign o_valid = (count_q != '0);
    assign o_data  = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; pointers wrap explicitly since DEPTH need not be a power of two
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= i_data;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/local_ram_pipe.sv
// Byte-lane scratchpad RAM: one write port, one credit-controlled read port
// with a 1- or 2-stage read pipe feeding an in-order FWFT response FIFO.
module local_ram_pipe
    import local_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned LANES        = 4,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clk_en,
    input  logic                  i_wr_en,
    input  logic [LANES-1:0]      i_wr_byte_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [8*LANES-1:0]    i_wr_data,
    output logic                  o_wr_err,
    input  logic                  i_rd_req_valid,
    output logic                  o_rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_rsp_valid,
    input  logic                  i_rd_rsp_ready,
    output logic [8*LANES-1:0]    o_rd_rsp_data,
    output logic                  o_rd_rsp_err
);

    localparam int unsigned DATA_W    = 8 * LANES;
    localparam int unsigned LANE_W    = $clog2(LANES);
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RSP_DEPTH = READ_LATENCY + 1;
    localparam int unsigned CRED_W    = $clog2(RSP_DEPTH + 1);

    logic [63:0]       wr_word, rd_word;
    logic              wr_in_range, rd_in_range;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_fire, rd_fire, collide, rsp_pop;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic              wr_err_q;
    logic              s1_valid_q, s1_err_q;
    logic [DATA_W-1:0] bank_rdata, s1_data;
    logic              push_valid;
    logic [DATA_W:0]   push_data, fifo_data;
    logic              fifo_valid;

    assign wr_word     = word_index(64'(i_wr_addr), LANE_W);
    assign rd_word     = word_index(64'(i_rd_addr), LANE_W);
    assign wr_in_range = (wr_word < 64'(DEPTH));
    assign rd_in_range = (rd_word < 64'(DEPTH));
    assign wr_idx      = wr_word[IDX_W-1:0];
    assign rd_idx      = rd_word[IDX_W-1:0];

    assign o_rd_req_ready = (credits_q != '0);
    assign wr_fire  = i_clk_en & i_wr_en & wr_in_range;
    assign rd_fire  = i_clk_en & i_rd_req_valid & o_rd_req_ready;
    assign collide  = wr_fire & rd_in_range & (rd_idx == wr_idx);
    assign rsp_pop  = i_clk_en & fifo_valid & i_rd_rsp_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_bank
        (* ram_style = "block" *) logic [7:0] mem [DEPTH];
        logic [7:0] dout_q;

        // Lane write plus registered read; an enabled same-word write is forwarded (write-first)
        always_ff @(posedge i_clk) begin
            if (wr_fire && i_wr_byte_en[k]) begin
                mem[wr_idx] <= i_wr_data[8*k +: 8];
            end
            if (rd_fire) begin
                if (collide && i_wr_byte_en[k]) begin
                    dout_q <= i_wr_data[8*k +: 8];
                end else begin
                    dout_q <= mem[rd_idx];
                end
            end
        end

        assign bank_rdata[8*k +: 8] = dout_q;
    end

    // First read stage: tracks which bank outputs hold a live response and whether it was out of range
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
        end else if (i_clk_en) begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                s1_err_q <= ~rd_in_range;
            end
        end
    end

    assign s1_data = s1_err_q ? '0 : bank_rdata;

    if (READ_LATENCY == 2) begin : g_lat2
        logic              s2_valid_q, s2_err_q;
        logic [DATA_W-1:0] s2_data_q;

        // Optional output register stage
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                s2_valid_q <= 1'b0;
                s2_err_q   <= 1'b0;
                s2_data_q  <= '0;
            end else if (i_clk_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_err_q  <= s1_err_q;
                    s2_data_q <= s1_data;
                end
            end
        end

        assign push_valid = s2_valid_q;
        assign push_data  = {s2_err_q, s2_data_q};
    end else begin : g_lat1
        assign push_valid = s1_valid_q;
        assign push_data  = {s1_err_q, s1_data};
    end

    local_ram_rsp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clk_en (i_clk_en),
        .i_push   (push_valid),
        .i_data   (push_data),
        .i_pop    (i_rd_rsp_ready),
        .o_valid  (fifo_valid),
        .o_data   (fifo_data)
    );

    assign o_rd_rsp_valid = fifo_valid;
    assign o_rd_rsp_err   = fifo_data[DATA_W];
    assign o_rd_rsp_data  = fifo_data[DATA_W-1:0];

    // Credit next-state: a request and a consume in the same cycle cancel out
    always_comb begin
        credits_d = credits_q;
        if (rd_fire && !rsp_pop) begin
            credits_d = credits_q - CRED_W'(1);
        end else if (!rd_fire && rsp_pop) begin
            credits_d = credits_q + CRED_W'(1);
        end
    end

    // Credit counter and write-error pulse, both frozen while stalled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credits_q <= CRED_W'(RSP_DEPTH);
            wr_err_q  <= 1'b0;
        end else if (i_clk_en) begin
            credits_q <= credits_d;
            wr_err_q  <= i_wr_en & ~wr_in_range;
        end
    end

    assign o_wr_err = wr_err_q;

endmodule
